async_reset_seq: RTL and testbench
==================================

Name: async_reset_seq

Overview:
Parametrised reset controller for the design's single clock domain. It captures several asynchronous reset requests, including sub-cycle glitches, plus one synchronous software request. It holds all reset outputs high for a programmable stretch, then releases them one at a time in index order with a fixed cycle gap. A sticky cause register records which sources triggered the reset. It sits between the pad-level reset inputs and the per-subsystem reset nets.

Parameters:
NUM_SRC, 2, number of asynchronous request inputs (>=1)
NUM_OUT, 3, number of sequenced reset outputs (>=1)
SYNC_STAGES, 2, synchroniser depth for requests and for the block's own reset (>=2)
HOLD_CYCLES, 4, clock edges reset is held after the last active request (>=1)
RELEASE_GAP, 2, clock edges between successive output releases (>=1)

Ports:
clk  in  1  single clock; all flops on posedge
async_reset_in  in  1  asynchronous, active-high master reset; asserts immediately, deasserts via internal SYNC_STAGES synchroniser
req_in  in  NUM_SRC  asynchronous active-high reset requests; level, pulse or glitch
sw_req  in  1  synchronous request, sampled on clk
cause_clr  in  1  synchronous clear of the cause register
reset_out  out  NUM_OUT  active-high resets; bit 0 releases first
done  out  1  high when every reset_out is low (state RUN)
cause  out  NUM_SRC+2  sticky: [NUM_SRC+1]=async_reset_in, [NUM_SRC]=sw_req, [i]=req_in[i]

Behaviour:
- Reset: async_reset_in=1 asynchronously forces reset_out=all 1s, done=0, state=ASSERT, cnt=HOLD_CYCLES-1, and cause[NUM_SRC+1]=1. Other cause bits keep their values. Internal rst_int is released on the SYNC_STAGES-th edge after async_reset_in falls. That edge counts as the last active request edge E_last.
- Per-source capture: a catch flop is asynchronously set by req_in[i], followed by a SYNC_STAGES chain. The last stage is req_act[i]. The catch flop clears on an edge where req_act[i]=1, but the set input dominates while req_in is high. Any pulse of any width therefore yields at least one req_act cycle.
- Request edge: an edge where any req_act or sw_req is sampled high.
- States: RUN, ASSERT, RELEASE. An index register idx (0..NUM_OUT-1) and a down-counter cnt of width clog2(max(HOLD_CYCLES,RELEASE_GAP)+1) drive the sequence.
- Any state, request edge: state<=ASSERT, reset_out<=all 1s, cnt<=HOLD_CYCLES-1, idx<=0, done<=0.
- ASSERT, no request edge: if cnt!=0, decrement. If cnt==0, reset_out[0]<=0 and cnt<=RELEASE_GAP-1. Then go to RUN if NUM_OUT==1, otherwise to RELEASE with idx<=1.
- RELEASE, no request edge: decrement while cnt!=0. At cnt==0, reset_out[idx]<=0 and cnt<=RELEASE_GAP-1. If idx==NUM_OUT-1, go to RUN with done<=1; otherwise idx++.
- Resulting timing: reset_out[k] falls on edge E_last + HOLD_CYCLES + k*RELEASE_GAP. done rises on the same edge as reset_out[NUM_OUT-1].
- A request during RELEASE aborts the sequence: every already-released output re-asserts one edge later and the hold restarts.
- Cause: on a request edge, bits for the sampled-active sources are set. cause_clr clears all bits on that edge, except that a set on the same edge wins.
- Assertion latency: async_reset_in acts at 0 cycles. req_in acts on the (SYNC_STAGES+1)-th edge after the rising input. sw_req acts on the same edge it is sampled.

Decomposition:
- Package async_reset_seq_pkg holds:
  - the state enum (RUN, ASSERT, RELEASE)
  - a CNT_W width function
  - cause bit index constants (CAUSE_POR, CAUSE_SW)
- One sub-module, async_req_catcher, is instantiated NUM_SRC times. It contains the async-set catch flop, the SYNC_STAGES chain and the clear-on-ack logic.
- One further instance serves as the rst_int synchroniser, with async assert and sync deassert.

Test Plan (defaults throughout):
- Power-on release: async_reset_in high, then falls between E0 and E1 -> reset_out[0] falls at E6, [1] at E8, [2] at E10; done=1 at E10; cause=4'b1000.
- Glitch: req_in[0] pulses 1 ns high between E0 and E1 while in RUN -> reset_out=3'b111 after E3; req_act high at E3..E5; reset_out[0..2] fall at E9/E11/E13; cause[0]=1.
- sw_req high for edge E0 only, in RUN -> reset_out=111 after E0; releases at E4/E6/E8.
- Abort: req_in[1] held high for 3 cycles starting just after reset_out[0] has fallen (E6 of the power-on sequence) -> reset_out[0] re-asserts; release restarts HOLD_CYCLES edges after the last req_act edge; cause[1]=1.
- Cause clear: cause_clr on the same edge as a sw_req request edge -> cause[NUM_SRC] remains 1, all other bits become 0.
- Mid-sequence reset: async_reset_in pulses during RELEASE -> all outputs go high immediately with no clock edge; the full power-on timing repeats from the new deassertion.

Source files
------------

// File: rtl/async_reset_seq_pkg.sv
// Shared types and helpers for the async_reset_seq reset controller.
package async_reset_seq_pkg;

    typedef enum logic [1:0] {
        RUN,
        ASSERT,
        RELEASE
    } state_e;

    // Cause bit positions, counted upward from the last req_in bit.
    localparam int CAUSE_SW  = 0;
    localparam int CAUSE_POR = 1;

    function automatic int cntWidth(input int hold, input int gap);
        int maxVal;
        maxVal = (hold > gap) ? hold : gap;
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/async_reset_seq_req_catcher.sv
// Captures one asynchronous reset request of any width and hands it to the clock domain.
module async_req_catcher #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic act_o
);

    logic              catch_q;
    logic [STAGES-1:0] sync_q;

    // While the request is high, the set input wins over both the reset and the acknowledge clear.
    always_ff @(posedge clk_i or posedge req_i or posedge rst_i) begin
        if (req_i) begin
            catch_q <= 1'b1;
        end else if (rst_i) begin
            catch_q <= 1'b0;
        end else if (act_o) begin
            catch_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], catch_q};
        end
    end

    assign act_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_reset_seq.sv
// Reset controller: gathers reset requests, holds every output, then releases them in index order.
module async_reset_seq
    import async_reset_seq_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int NUM_OUT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int RELEASE_GAP = 2
) (
    input  logic               clk,
    input  logic               async_reset_in,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic               sw_req,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               done,
    output logic [NUM_SRC+1:0] cause
);

    localparam int CNT_W   = cntWidth(HOLD_CYCLES, RELEASE_GAP);
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int SW_BIT  = NUM_SRC + CAUSE_SW;
    localparam int POR_BIT = NUM_SRC + CAUSE_POR;

    logic [SYNC_STAGES-1:0] rstSync_q;
    logic                   rstInt;
    logic [NUM_SRC-1:0]     reqAct;
    logic                   reqEdge;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rstOut_q, rstOut_d;
    logic               done_q, done_d;
    logic [SW_BIT:0]    causeLo_q;
    logic               causePor_q;

    // Master reset asserts at once and leaves on the SYNC_STAGES-th edge after it drops.
    always_ff @(posedge clk or posedge async_reset_in) begin
        if (async_reset_in) begin
            rstSync_q <= '1;
        end else begin
            rstSync_q <= {rstSync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rstInt = rstSync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_catch
        async_req_catcher #(
            .STAGES(SYNC_STAGES)
        ) u_catch (
            .clk_i(clk),
            .rst_i(rstInt),
            .req_i(req_in[i]),
            .act_o(reqAct[i])
        );
    end

    assign reqEdge = (|reqAct) | sw_req;

    always_ff @(posedge clk or posedge rstInt) begin
        if (rstInt) begin
            state_q  <= ASSERT;
            cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
            idx_q    <= '0;
            rstOut_q <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rstOut_q <= rstOut_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rstOut_d = rstOut_q;
        done_d   = done_q;
        if (reqEdge) begin
            state_d  = ASSERT;
            cnt_d    = CNT_W'(HOLD_CYCLES - 1);
            idx_d    = '0;
            rstOut_d = '1;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rstOut_d[0] = 1'b0;
                        cnt_d       = CNT_W'(RELEASE_GAP - 1);
                        if (NUM_OUT == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rstOut_d[idx_q] = 1'b0;
                        cnt_d           = CNT_W'(RELEASE_GAP - 1);
                        if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // A set on the same edge as a clear wins, so the newest cause is never lost.
    always_ff @(posedge clk) begin
        if (cause_clr) begin
            causeLo_q <= {sw_req, reqAct};
        end else begin
            causeLo_q <= causeLo_q | {sw_req, reqAct};
        end
    end

    always_ff @(posedge clk or posedge rstInt) begin
        if (rstInt) begin
            causePor_q <= 1'b1;
        end else if (cause_clr) begin
            causePor_q <= 1'b0;
        end
    end

    assign cause[SW_BIT:0] = causeLo_q;
    assign cause[POR_BIT]  = causePor_q;
    assign reset_out       = rstOut_q;
    assign done            = done_q;

endmodule

// File: tb/tb_async_reset_seq.sv
// Directed bench for async_reset_seq: power-on, glitch, software, cause clear, abort and mid-release reset.
module tb_async_reset_seq;

    localparam int NUM_SRC = 2;
    localparam int NUM_OUT = 3;
    localparam int HOLD    = 4;
    localparam int GAP     = 2;

    logic               clk = 1'b0;
    logic               async_reset_in;
    logic [NUM_SRC-1:0] req_in;
    logic               sw_req;
    logic               cause_clr;
    logic [NUM_OUT-1:0] reset_out;
    logic               done;
    logic [NUM_SRC+1:0] cause;

    int assertCount = 0;
    int failCount   = 0;
    int edgeNo      = 0;

    always #5 clk = ~clk;

    async_reset_seq #(
        .NUM_SRC(NUM_SRC),
        .NUM_OUT(NUM_OUT),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(HOLD),
        .RELEASE_GAP(GAP)
    ) dut (
        .clk(clk),
        .async_reset_in(async_reset_in),
        .req_in(req_in),
        .sw_req(sw_req),
        .cause_clr(cause_clr),
        .reset_out(reset_out),
        .done(done),
        .cause(cause)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic [NUM_SRC-1:0] req, input logic sw, input logic clr);
        async_reset_in = rstIn;
        req_in         = req;
        sw_req         = sw;
        cause_clr      = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edgeNo++;
    endtask

    // Output k falls on edge eLast + HOLD + k*GAP.
    function automatic logic [NUM_OUT-1:0] expOut(input int k, input int eLast);
        logic [NUM_OUT-1:0] v;
        for (int j = 0; j < NUM_OUT; j++) begin
            v[j] = (k < eLast + HOLD + j * GAP);
        end
        return v;
    endfunction

    task automatic checkNow(input string tag, input int eLast);
        logic expDone;
        expDone = (edgeNo >= eLast + HOLD + (NUM_OUT - 1) * GAP);
        checkOutput({tag, " reset_out"}, 32'(reset_out), 32'(expOut(edgeNo, eLast)));
        checkOutput({tag, " done"}, 32'(done), 32'(expDone));
    endtask

    task automatic checkUntil(input string tag, input int eLast, input int kEnd);
        while (edgeNo < kEnd) begin
            tick();
            checkNow(tag, eLast);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on: hold reset and clear stale cause bits
        applyStimulus(1'b1, '0, 1'b0, 1'b1);
        #1;
        checkOutput("por immediate reset_out", 32'(reset_out), 32'(3'b111));
        repeat (3) tick();
        checkOutput("por hold reset_out", 32'(reset_out), 32'(3'b111));
        checkOutput("por hold done", 32'(done), 32'(1'b0));
        checkOutput("por hold cause", 32'(cause), 32'(4'b1000));
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        tick();
        edgeNo = 0;
        #1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkUntil("por", 2, 12);
        checkOutput("por cause", 32'(cause), 32'(4'b1000));

        // 1 ns glitch on req_in[0]; last request edge is E5
        tick();
        edgeNo = 0;
        #1;
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        #1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("glitch pre reset_out", 32'(reset_out), 32'(3'b000));
        checkOutput("glitch pre done", 32'(done), 32'(1'b1));
        checkUntil("glitch", 5, 14);
        checkOutput("glitch cause", 32'(cause), 32'(4'b1001));

        // Software request sampled on E0
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        edgeNo = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkNow("sw", 0);
        checkUntil("sw", 0, 10);
        checkOutput("sw cause", 32'(cause), 32'(4'b1101));

        // Cause clear coinciding with a software request
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick();
        edgeNo = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clr cause", 32'(cause), 32'(4'b0100));
        checkNow("clr", 0);
        checkUntil("clr", 0, 10);

        // Power-on again, then req_in[1] held E6+ to E9+ aborts the release
        tick();
        edgeNo = 0;
        #1;
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        #1;
        checkOutput("abort por immediate reset_out", 32'(reset_out), 32'(3'b111));
        #2;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkUntil("abort pre", 2, 6);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        checkUntil("abort pre", 2, 8);
        tick();
        checkOutput("abort reassert reset_out", 32'(reset_out), 32'(3'b111));
        checkOutput("abort reassert done", 32'(done), 32'(1'b0));
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkUntil("abort", 12, 20);
        checkOutput("abort cause", 32'(cause), 32'(4'b1110));

        // Master reset pulse in the middle of a release sequence
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        edgeNo = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkNow("mid sw", 0);
        checkUntil("mid sw", 0, 5);
        #2;
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        #1;
        checkOutput("mid immediate reset_out", 32'(reset_out), 32'(3'b111));
        checkOutput("mid immediate done", 32'(done), 32'(1'b0));
        #2;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkUntil("mid repeat", 7, 17);
        checkOutput("mid cause", 32'(cause), 32'(4'b1110));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
